// File: rtl/rx_cmd_dispatcher_pkg.sv
// Shared serial-protocol definitions: opcodes, response types, error tag
// and the dispatcher FSM encoding used by the RX/TX stages.
package rx_cmd_dispatcher_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_PING  = 4'h3;

  localparam logic [3:0] RESP_ACK  = 4'h1;
  localparam logic [3:0] RESP_DATA = 4'h2;
  localparam logic [3:0] RESP_ECHO = 4'h3;
  localparam logic [3:0] RESP_ERR  = 4'hE;

  localparam logic [7:0] ERR_TAG_DEFAULT = 8'hEE;
  localparam int         ECHO_DEPTH      = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_RESP_WAIT = 3'd4,
    ST_RESP_WR   = 3'd5,
    ST_DRAIN     = 3'd6
  } state_t;

  function automatic logic [15:0] err_word(input logic [7:0] tag, input logic [3:0] op);
    return {tag, 4'h0, op};
  endfunction

endpackage

// File: rtl/rx_cmd_dispatcher_reg_file.sv
// Command register file: one synchronous write port, two combinational
// read ports (config readback and response generation).
module cmd_reg_file
  import rx_cmd_dispatcher_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr_a,
  output logic [15:0] rdata_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_b
);

  logic [15:0] regs_r [NUM_REGS];

  // write port with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if (we && (int'(waddr) < NUM_REGS)) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (int'(raddr_a) < NUM_REGS) ? regs_r[raddr_a] : 16'h0000;
  assign rdata_b = (int'(raddr_b) < NUM_REGS) ? regs_r[raddr_b] : 16'h0000;

endmodule

// File: rtl/rx_cmd_dispatcher.sv
// Decodes packets from the serial RX stage, executes WRITE/READ/PING against
// the register file and echo buffer, and streams the response to the TX stage.
module rx_cmd_dispatcher
  import rx_cmd_dispatcher_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] ERR_TAG  = ERR_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rx_word,
  input  logic        new_rx_words,
  input  logic [3:0]  rx_word_cnt,
  input  logic [3:0]  opcode,
  output logic        read_rx_word,
  output logic [15:0] tx_word,
  output logic        write_tx_word,
  output logic [3:0]  tx_word_cnt,
  output logic [3:0]  tx_resp_type,
  input  logic        tx_busy,
  input  logic [3:0]  cfg_addr,
  output logic [15:0] cfg_data
);

  state_t      state_r, state_nxt_s;
  logic [3:0]  op_r, cnt_r, idx_r, base_addr_r;
  logic [3:0]  tx_idx_r, tx_cnt_r, tx_type_r;
  logic        err_r, read_rx_word_r;
  logic [15:0] rd_cnt_r, tx_word_r;
  logic [15:0] echo_r [ECHO_DEPTH];

  logic        hdr_err_s, pop_s, wr_s, rf_we_s;
  logic [3:0]  exec_type_s, exec_cnt_s, resp_type_s, tx_sel_idx_s;
  logic [3:0]  rf_waddr_s, rf_raddr_s;
  logic [15:0] rf_rdata_s, echo_word_s, resp_word_s;

  cmd_reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we_s),
    .waddr   (rf_waddr_s),
    .wdata   (rx_word),
    .raddr_a (cfg_addr),
    .rdata_a (cfg_data),
    .raddr_b (rf_raddr_s),
    .rdata_b (rf_rdata_s)
  );

  // Data words follow the address word, so word i lands at base + i - 1.
  assign rf_we_s    = (state_r == ST_FETCH) && new_rx_words && (op_r == OP_WRITE) && (idx_r != 4'd0);
  assign rf_waddr_s = base_addr_r + idx_r - 4'd1;
  assign pop_s      = ((state_r == ST_FETCH) || (state_r == ST_DRAIN)) && new_rx_words;
  assign wr_s       = (state_r == ST_RESP_WR) && !tx_busy;

  // tx_word_r always holds the word at tx_idx_r; prefetch the next one on each write.
  assign tx_sel_idx_s = (state_r == ST_RESP_WR) ? (tx_idx_r + 4'd1) : 4'd0;
  assign rf_raddr_s   = base_addr_r + tx_sel_idx_s;
  assign echo_word_s  = (tx_sel_idx_s < 4'(ECHO_DEPTH)) ? echo_r[tx_sel_idx_s] : 16'h0000;

  // header checks that are decidable before any word is read
  always_comb begin
    hdr_err_s = 1'b0;
    case (opcode)
      OP_WRITE: hdr_err_s = (rx_word_cnt < 4'd2);
      OP_READ:  hdr_err_s = (rx_word_cnt != 4'd2);
      OP_PING:  hdr_err_s = 1'b0;
      default:  hdr_err_s = 1'b1;
    endcase
  end

  // response type and length once the packet is consumed
  always_comb begin
    exec_type_s = RESP_ERR;
    exec_cnt_s  = 4'd1;
    if (err_r) begin
      exec_type_s = RESP_ERR;
      exec_cnt_s  = 4'd1;
    end else begin
      case (op_r)
        OP_WRITE: begin
          exec_type_s = RESP_ACK;
          exec_cnt_s  = 4'd1;
        end
        OP_READ: begin
          if ((rd_cnt_r == 16'd0) || (rd_cnt_r > 16'd15)) begin
            exec_type_s = RESP_ERR;
            exec_cnt_s  = 4'd1;
          end else begin
            exec_type_s = RESP_DATA;
            exec_cnt_s  = rd_cnt_r[3:0];
          end
        end
        OP_PING: begin
          exec_type_s = RESP_ECHO;
          exec_cnt_s  = cnt_r;
        end
        default: begin
          exec_type_s = RESP_ERR;
          exec_cnt_s  = 4'd1;
        end
      endcase
    end
  end

  // response word source selection
  always_comb begin
    resp_type_s = (state_r == ST_EXEC) ? exec_type_s : tx_type_r;
    resp_word_s = err_word(ERR_TAG, op_r);
    case (resp_type_s)
      RESP_ACK:  resp_word_s = {12'h000, cnt_r - 4'd1};
      RESP_DATA: resp_word_s = rf_rdata_s;
      RESP_ECHO: resp_word_s = echo_word_s;
      default:   resp_word_s = err_word(ERR_TAG, op_r);
    endcase
  end

  // FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!new_rx_words)              state_nxt_s = ST_IDLE;
        else if (rx_word_cnt == 4'd0)   state_nxt_s = ST_EXEC;
        else if (hdr_err_s)             state_nxt_s = ST_DRAIN;
        else                            state_nxt_s = ST_FETCH;
      end
      ST_FETCH, ST_DRAIN: begin
        if (new_rx_words) state_nxt_s = ST_SETTLE;
        else              state_nxt_s = ST_EXEC;
      end
      ST_SETTLE: begin
        if (idx_r == cnt_r) state_nxt_s = ST_EXEC;
        else if (err_r)     state_nxt_s = ST_DRAIN;
        else                state_nxt_s = ST_FETCH;
      end
      ST_EXEC:      state_nxt_s = ST_RESP_WAIT;
      ST_RESP_WAIT: begin
        if (tx_busy) state_nxt_s = ST_RESP_WAIT;
        else         state_nxt_s = ST_RESP_WR;
      end
      ST_RESP_WR: begin
        if (tx_busy)                           state_nxt_s = ST_RESP_WAIT;
        else if (tx_idx_r == tx_cnt_r - 4'd1)  state_nxt_s = ST_IDLE;
        else                                   state_nxt_s = ST_RESP_WR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // packet capture, echo buffer and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r           <= 4'h0;
      cnt_r          <= 4'h0;
      idx_r          <= 4'h0;
      base_addr_r    <= 4'h0;
      err_r          <= 1'b0;
      rd_cnt_r       <= 16'h0000;
      read_rx_word_r <= 1'b0;
      tx_idx_r       <= 4'h0;
      tx_cnt_r       <= 4'h0;
      tx_type_r      <= 4'h0;
      tx_word_r      <= 16'h0000;
      for (int i = 0; i < ECHO_DEPTH; i++) begin
        echo_r[i] <= 16'h0000;
      end
    end else begin
      read_rx_word_r <= pop_s;
      case (state_r)
        ST_IDLE: begin
          if (new_rx_words) begin
            op_r     <= opcode;
            cnt_r    <= rx_word_cnt;
            idx_r    <= 4'd0;
            rd_cnt_r <= 16'h0000;
            err_r    <= hdr_err_s || (rx_word_cnt == 4'd0);
          end
        end
        ST_FETCH: begin
          if (new_rx_words) begin
            idx_r <= idx_r + 4'd1;
            if (idx_r == 4'd0) base_addr_r <= rx_word[3:0];
            if ((op_r == OP_READ) && (idx_r == 4'd1)) rd_cnt_r <= rx_word;
            if ((op_r == OP_PING) && (idx_r < 4'(ECHO_DEPTH))) echo_r[idx_r] <= rx_word;
          end else begin
            err_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (new_rx_words) idx_r <= idx_r + 4'd1;
        end
        ST_EXEC: begin
          tx_type_r <= exec_type_s;
          tx_cnt_r  <= exec_cnt_s;
          tx_idx_r  <= 4'd0;
          tx_word_r <= resp_word_s;
        end
        ST_RESP_WR: begin
          if (wr_s) begin
            tx_idx_r  <= tx_idx_r + 4'd1;
            tx_word_r <= resp_word_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_rx_word  = read_rx_word_r;
  assign tx_word       = tx_word_r;
  assign write_tx_word = wr_s && !rst;
  assign tx_word_cnt   = tx_cnt_r;
  assign tx_resp_type  = tx_type_r;

endmodule

// File: tb/tb_rx_cmd_dispatcher.sv
// Directed scoreboard bench for rx_cmd_dispatcher with a simple RX-stage model.
module tb_rx_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_word;
  logic        new_rx_words;
  logic [3:0]  rx_word_cnt;
  logic [3:0]  opcode;
  logic        read_rx_word;
  logic [15:0] tx_word;
  logic        write_tx_word;
  logic [3:0]  tx_word_cnt;
  logic [3:0]  tx_resp_type;
  logic        tx_busy = 1'b0;
  logic [3:0]  cfg_addr = 4'h0;
  logic [15:0] cfg_data;

  typedef struct packed {
    logic [15:0] w;
    logic [3:0]  c;
    logic [3:0]  t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_regs [16];
  int          tests = 0;
  int          fails = 0;
  int          pops = 0;
  int          wr_seen = 0;
  int          pops_base = 0;
  int          wr_base = 0;

  // RX stage model: packet words served in order, advanced by read_rx_word
  logic [15:0] pkt_w [16];
  int          pkt_len = 0;
  logic [3:0]  pkt_op = 4'h0;
  logic        pkt_active = 1'b0;
  logic        pkt_zero = 1'b0;
  int          pkt_start = 0;
  int          total_pops = 0;
  int          rx_idx;

  assign rx_idx       = total_pops - pkt_start;
  assign new_rx_words = pkt_active && ((rx_idx < pkt_len) || pkt_zero);
  assign rx_word      = ((rx_idx >= 0) && (rx_idx < 16)) ? pkt_w[rx_idx[3:0]] : 16'h0000;
  assign rx_word_cnt  = pkt_len[3:0];
  assign opcode       = pkt_op;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_rx_word) total_pops <= total_pops + 1;
  end

  rx_cmd_dispatcher dut (
    .clk          (clk),
    .rst          (rst),
    .rx_word      (rx_word),
    .new_rx_words (new_rx_words),
    .rx_word_cnt  (rx_word_cnt),
    .opcode       (opcode),
    .read_rx_word (read_rx_word),
    .tx_word      (tx_word),
    .write_tx_word(write_tx_word),
    .tx_word_cnt  (tx_word_cnt),
    .tx_resp_type (tx_resp_type),
    .tx_busy      (tx_busy),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor: counts pops, pops scoreboard on every TX write
  always @(negedge clk) begin
    if (read_rx_word) pops <= pops + 1;
    if (write_tx_word) begin
      wr_seen <= wr_seen + 1;
      check("write_while_busy", 32'(tx_busy), 32'd0);
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("tx_word", 32'(tx_word), 32'(mon_e.w));
        check("tx_word_cnt", 32'(tx_word_cnt), 32'(mon_e.c));
        check("tx_resp_type", 32'(tx_resp_type), 32'(mon_e.t));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [3:0] op, input int n);
    exp_t e;
    int   cnt;
    logic bad;
    bad = (n == 0) || !(op inside {4'h1, 4'h2, 4'h3}) || ((op == 4'h1) && (n < 2)) ||
          ((op == 4'h2) && ((n != 2) || (pkt_w[1] == 16'h0000) || (pkt_w[1] > 16'd15)));
    if (bad) begin
      e = '{w: {8'hEE, 4'h0, op}, c: 4'd1, t: 4'hE};
      sb.push_back(e);
    end else if (op == 4'h1) begin
      for (int i = 1; i < n; i++) model_regs[(int'(pkt_w[0][3:0]) + i - 1) % 16] = pkt_w[i];
      e = '{w: 16'(n - 1), c: 4'd1, t: 4'h1};
      sb.push_back(e);
    end else if (op == 4'h2) begin
      cnt = int'(pkt_w[1]);
      for (int i = 0; i < cnt; i++) begin
        e = '{w: model_regs[(int'(pkt_w[0][3:0]) + i) % 16], c: 4'(cnt), t: 4'h2};
        sb.push_back(e);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        e = '{w: pkt_w[i], c: 4'(n), t: 4'h3};
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_pkt(input logic [3:0] op, input int n);
    pkt_op     = op;
    pkt_len    = n;
    pkt_start  = total_pops;
    pops_base  = pops;
    wr_base    = wr_seen;
    pkt_zero   = (n == 0);
    pkt_active = 1'b1;
    if (n == 0) begin
      tick(1);
      pkt_zero = 1'b0;
    end
  endtask

  task automatic wait_sb_empty(input string tag, input int budget);
    int k = 0;
    while ((sb.size() != 0) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    tick(3);
  endtask

  task automatic run_pkt(input string tag, input logic [3:0] op, input int n, input int exp_pops);
    push_expected(op, n);
    start_pkt(op, n);
    wait_sb_empty({tag, "_resp_done"}, 300);
    check({tag, "_pops"}, 32'(pops - pops_base), 32'(exp_pops));
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    cfg_addr = addr;
    #1;
    check(tag, 32'(cfg_data), 32'(exp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_read"}, 32'(read_rx_word), 32'd0);
    check({tag, "_write"}, 32'(write_tx_word), 32'd0);
    check({tag, "_tx_word"}, 32'(tx_word), 32'd0);
    check({tag, "_tx_cnt"}, 32'(tx_word_cnt), 32'd0);
    check({tag, "_tx_type"}, 32'(tx_resp_type), 32'd0);
  endtask

  initial begin
    int k;
    int p0;
    int w0;
    for (int i = 0; i < 16; i++) begin
      model_regs[i] = 16'h0000;
      pkt_w[i]      = 16'h0000;
    end

    rst = 1'b1;
    tick(3);
    chk_idle_outputs("reset");
    chk_reg("reset_reg3", 4'd3, 16'h0000);
    rst = 1'b0;
    tick(1);

    // WRITE {3,A,B,C}
    pkt_w[0] = 16'h0003; pkt_w[1] = 16'h000A; pkt_w[2] = 16'h000B; pkt_w[3] = 16'h000C;
    run_pkt("wr4", 4'h1, 4, 4);
    chk_reg("wr4_reg3", 4'd3, 16'h000A);
    chk_reg("wr4_reg4", 4'd4, 16'h000B);
    chk_reg("wr4_reg5", 4'd5, 16'h000C);

    // WRITE {15,1,2} then READ {15,2}: address wraps 15 -> 0
    pkt_w[0] = 16'h000F; pkt_w[1] = 16'h0001; pkt_w[2] = 16'h0002;
    run_pkt("wr_wrap", 4'h1, 3, 3);
    pkt_w[0] = 16'h000F; pkt_w[1] = 16'h0002;
    run_pkt("rd_wrap", 4'h2, 2, 2);
    chk_reg("wrap_reg0", 4'd0, 16'h0002);

    // PING held off by tx_busy
    tx_busy = 1'b1;
    pkt_w[0] = 16'h1234; pkt_w[1] = 16'h5678; pkt_w[2] = 16'h9ABC;
    push_expected(4'h3, 3);
    start_pkt(4'h3, 3);
    tick(20);
    check("ping_no_write_while_busy", 32'(wr_seen - wr_base), 32'd0);
    check("ping_pops", 32'(pops - pops_base), 32'd3);
    tx_busy = 1'b0;
    wait_sb_empty("ping_resp_done", 100);
    check("ping_writes", 32'(wr_seen - wr_base), 32'd3);

    // unknown opcode and zero-count READ
    pkt_w[0] = 16'h0001; pkt_w[1] = 16'h0002;
    run_pkt("badop", 4'h7, 2, 2);
    pkt_w[0] = 16'h0000; pkt_w[1] = 16'h0000;
    run_pkt("rd_cnt0", 4'h2, 2, 2);
    pkt_w[0] = 16'h0005;
    run_pkt("wr_short", 4'h1, 1, 1);

    // READ of 4 words with tx_busy pulsed after the 2nd write
    pkt_w[0] = 16'h0008; pkt_w[1] = 16'h0011; pkt_w[2] = 16'h0022;
    pkt_w[3] = 16'h0033; pkt_w[4] = 16'h0044;
    run_pkt("wr8", 4'h1, 5, 5);
    pkt_w[0] = 16'h0008; pkt_w[1] = 16'h0004;
    push_expected(4'h2, 2);
    start_pkt(4'h2, 2);
    k = 0;
    while (((wr_seen - wr_base) < 2) && (k < 200)) begin
      tick(1);
      k++;
    end
    check("rd4_two_writes", 32'(wr_seen - wr_base), 32'd2);
    tx_busy = 1'b1;
    tick(4);
    check("rd4_paused", 32'(wr_seen - wr_base), 32'd2);
    tx_busy = 1'b0;
    wait_sb_empty("rd4_resp_done", 100);
    check("rd4_writes", 32'(wr_seen - wr_base), 32'd4);

    // zero-length packet
    run_pkt("zero_cnt", 4'h1, 0, 0);

    // abort: new_rx_words drops after the first pop
    pkt_w[0] = 16'h0101; pkt_w[1] = 16'h0202; pkt_w[2] = 16'h0303; pkt_w[3] = 16'h0404;
    sb.push_back('{w: 16'hEE03, c: 4'd1, t: 4'hE});
    start_pkt(4'h3, 4);
    k = 0;
    while (((pops - pops_base) < 1) && (k < 200)) begin
      tick(1);
      k++;
    end
    pkt_active = 1'b0;
    wait_sb_empty("abort_resp_done", 100);
    check("abort_pops", 32'(pops - pops_base), 32'd1);

    // reset during FETCH of a 5-word WRITE
    pkt_w[0] = 16'h0002; pkt_w[1] = 16'h0AAA; pkt_w[2] = 16'h0BBB;
    pkt_w[3] = 16'h0CCC; pkt_w[4] = 16'h0DDD;
    start_pkt(4'h1, 5);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pkt_active = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    chk_idle_outputs("midrst");
    chk_reg("midrst_reg3", 4'd3, 16'h0000);
    chk_reg("midrst_reg8", 4'd8, 16'h0000);
    p0 = pops;
    w0 = wr_seen;
    tick(5);
    check("midrst_no_pops", 32'(pops - p0), 32'd0);
    check("midrst_no_writes", 32'(wr_seen - w0), 32'd0);
    pkt_w[0] = 16'h0006; pkt_w[1] = 16'h0055;
    run_pkt("post_rst_wr", 4'h1, 2, 2);
    chk_reg("post_rst_reg6", 4'd6, 16'h0055);
    chk_reg("post_rst_reg2", 4'd2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
